// File: rtl/apb_rw_scheduler_if.sv
// Request/response channels and APB bus bundles for apb_rw_scheduler.
// master drives requests (or the APB bus); slave answers them.
interface apb_rw_scheduler_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);
    logic                    wr_req_valid_i;
    logic                    wr_req_ready_o;
    logic [ADDR_WIDTH-1:0]   wr_addr_i;
    logic [DATA_WIDTH-1:0]   wr_data_i;
    logic [DATA_WIDTH/8-1:0] wr_strb_i;
    logic                    wr_rsp_valid_o;
    logic                    wr_rsp_ready_i;
    logic                    wr_rsp_err_o;
    logic                    rd_req_valid_i;
    logic                    rd_req_ready_o;
    logic [ADDR_WIDTH-1:0]   rd_addr_i;
    logic                    rd_rsp_valid_o;
    logic                    rd_rsp_ready_i;
    logic [DATA_WIDTH-1:0]   rd_rsp_data_o;
    logic                    rd_rsp_err_o;

    modport master (
        output wr_req_valid_i, wr_addr_i, wr_data_i, wr_strb_i,
        output wr_rsp_ready_i, rd_req_valid_i, rd_addr_i,
        output rd_rsp_ready_i,
        input  wr_req_ready_o, wr_rsp_valid_o, wr_rsp_err_o,
        input  rd_req_ready_o, rd_rsp_valid_o, rd_rsp_data_o,
        input  rd_rsp_err_o
    );

    modport slave (
        input  wr_req_valid_i, wr_addr_i, wr_data_i, wr_strb_i,
        input  wr_rsp_ready_i, rd_req_valid_i, rd_addr_i,
        input  rd_rsp_ready_i,
        output wr_req_ready_o, wr_rsp_valid_o, wr_rsp_err_o,
        output rd_req_ready_o, rd_rsp_valid_o, rd_rsp_data_o,
        output rd_rsp_err_o
    );
endinterface

interface apb_rw_scheduler_apb_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   paddr_o;
    logic                    pwrite_o;
    logic                    psel_o;
    logic                    penable_o;
    logic [DATA_WIDTH-1:0]   pwdata_o;
    logic [DATA_WIDTH/8-1:0] pstrb_o;
    logic                    pready_i;
    logic [DATA_WIDTH-1:0]   prdata_i;
    logic                    pslverr_i;

    modport master (
        output paddr_o, pwrite_o, psel_o, penable_o, pwdata_o, pstrb_o,
        input  pready_i, prdata_i, pslverr_i
    );

    modport slave (
        input  paddr_o, pwrite_o, psel_o, penable_o, pwdata_o, pstrb_o,
        output pready_i, prdata_i, pslverr_i
    );
endinterface

// File: rtl/apb_rw_scheduler.sv
// Round-robin write/read request scheduler onto a single APB master port.
// Define APB_RW_SCHED_TIMEOUT_EN to abandon ACCESS after TIMEOUT_CYCLES waits.
module apb_rw_scheduler #(
    parameter int ADDR_WIDTH     = 12,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input logic                    clk_i,
    input logic                    rst_i,
    apb_rw_scheduler_if.slave      req,
    apb_rw_scheduler_apb_if.master apb
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

    state_e                state_q, state_d;
    logic                  last_wr_q, last_wr_d;
    logic                  is_wr_q, is_wr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0] strb_q, strb_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic                  grant_wr, grant_rd;
    logic                  rsp_taken;

`ifdef APB_RW_SCHED_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
`endif

    // Write wins a tie unless it also won the previous grant.
    assign grant_wr = req.wr_req_valid_i & (~req.rd_req_valid_i | ~last_wr_q);
    assign grant_rd = req.rd_req_valid_i & ~grant_wr;
    assign rsp_taken = is_wr_q ? req.wr_rsp_ready_i : req.rd_rsp_ready_i;

    always_comb begin
        state_d   = state_q;
        last_wr_d = last_wr_q;
        is_wr_d   = is_wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        strb_d    = strb_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        req.wr_req_ready_o = 1'b0;
        req.rd_req_ready_o = 1'b0;
`ifdef APB_RW_SCHED_TIMEOUT_EN
        cnt_d = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                req.wr_req_ready_o = grant_wr;
                req.rd_req_ready_o = grant_rd;
                if (grant_wr | grant_rd) begin
                    is_wr_d   = grant_wr;
                    last_wr_d = grant_wr;
                    addr_d    = grant_wr ? req.wr_addr_i : req.rd_addr_i;
                    wdata_d   = grant_wr ? req.wr_data_i : '0;
                    strb_d    = grant_wr ? req.wr_strb_i : '0;
                    rdata_d   = '0;
                    err_d     = 1'b0;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
`ifdef APB_RW_SCHED_TIMEOUT_EN
                cnt_d = '0;
`endif
            end
            ACCESS: begin
                if (apb.pready_i) begin
                    rdata_d = is_wr_q ? '0 : apb.prdata_i;
                    err_d   = apb.pslverr_i;
                    state_d = RESP;
                end
`ifdef APB_RW_SCHED_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            RESP: begin
                if (rsp_taken) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            last_wr_q <= 1'b0;
            is_wr_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            strb_q    <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_wr_q <= last_wr_d;
            is_wr_q   <= is_wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            strb_q    <= strb_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

`ifdef APB_RW_SCHED_TIMEOUT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
`endif

    assign apb.psel_o    = (state_q == SETUP) | (state_q == ACCESS);
    assign apb.penable_o = (state_q == ACCESS);
    assign apb.paddr_o   = addr_q;
    assign apb.pwrite_o  = is_wr_q;
    assign apb.pwdata_o  = wdata_q;
    assign apb.pstrb_o   = strb_q;

    assign req.wr_rsp_valid_o = (state_q == RESP) & is_wr_q;
    assign req.rd_rsp_valid_o = (state_q == RESP) & ~is_wr_q;
    assign req.wr_rsp_err_o   = req.wr_rsp_valid_o & err_q;
    assign req.rd_rsp_err_o   = req.rd_rsp_valid_o & err_q;
    assign req.rd_rsp_data_o  = req.rd_rsp_valid_o ? rdata_q : '0;
endmodule

// File: tb/tb_apb_rw_scheduler.sv
// Bench for apb_rw_scheduler: directed scenarios plus random traffic,
// all checked against a transaction-level model of the scheduler.
module tb_apb_rw_scheduler;
    localparam int AW  = 12;
    localparam int DW  = 32;
    localparam int TMO = 16;
    localparam int P_IDLE = 0, P_SETUP = 1, P_ACCESS = 2, P_RESP = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    apb_rw_scheduler_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) rq ();
    apb_rw_scheduler_apb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) apb ();

    apb_rw_scheduler #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_i(clk), .rst_i(rst), .req(rq.slave), .apb(apb.master)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc++;

    // APB completer: fixed wait count or fully random pready/prdata/pslverr
    bit          slv_rand  = 1'b0;
    int          slv_waits = 0;
    logic [31:0] slv_rdata = '0;
    logic        slv_err   = 1'b0;
    int          s_acc     = 0;
    always @(posedge clk) begin
        #1;
        if (slv_rand) begin
            apb.pready_i  = ($urandom % 3) == 0;
            apb.prdata_i  = $urandom;
            apb.pslverr_i = ($urandom % 4) == 0;
        end else begin
            apb.pready_i  = apb.penable_o && (s_acc >= slv_waits);
            apb.prdata_i  = slv_rdata;
            apb.pslverr_i = slv_err;
        end
        s_acc = apb.penable_o ? s_acc + 1 : 0;
    end

    // Transaction-level reference: who should win, what the bus should
    // carry, and what comes back, derived from the request stream.
    bit          m_armed = 1'b0;
    int          m_ph = P_IDLE;
    bit          m_wr, m_last_wr;
    logic [11:0] m_addr;
    logic [31:0] m_data, m_rdata;
    logic [3:0]  m_strb;
    bit          m_err;
    int          m_wait;
    bit          gw, gr;
    bit          grants[$];
    int          hs_cyc = 0;
    int          both_rdy = 0;
    int          pen_run = 0, last_pen_run = 0;

    always @(negedge clk) begin
        gw = rq.wr_req_valid_i && (!rq.rd_req_valid_i || !m_last_wr);
        gr = rq.rd_req_valid_i && !gw;
        if (m_armed) begin
            check("wr_req_ready", rq.wr_req_ready_o, m_ph == P_IDLE && gw);
            check("rd_req_ready", rq.rd_req_ready_o, m_ph == P_IDLE && gr);
            check("psel", apb.psel_o, m_ph == P_SETUP || m_ph == P_ACCESS);
            check("penable", apb.penable_o, m_ph == P_ACCESS);
            if (m_ph == P_SETUP || m_ph == P_ACCESS) begin
                check("paddr", apb.paddr_o, m_addr);
                check("pwrite", apb.pwrite_o, m_wr);
                check("pstrb", apb.pstrb_o, m_strb);
                if (m_wr) check("pwdata", apb.pwdata_o, m_data);
            end
            check("wr_rsp_valid", rq.wr_rsp_valid_o, m_ph == P_RESP && m_wr);
            check("rd_rsp_valid", rq.rd_rsp_valid_o, m_ph == P_RESP && !m_wr);
            if (m_ph == P_RESP) begin
                if (m_wr) begin
                    check("wr_rsp_err", rq.wr_rsp_err_o, m_err);
                    check("rd_data_on_wr", rq.rd_rsp_data_o, 0);
                end else begin
                    check("rd_rsp_err", rq.rd_rsp_err_o, m_err);
                    check("rd_rsp_data", rq.rd_rsp_data_o, m_rdata);
                end
            end
        end
        if (rq.wr_req_ready_o === 1'b1 && rq.rd_req_ready_o === 1'b1)
            both_rdy++;
        if (apb.penable_o === 1'b1) pen_run++;
        else begin
            if (pen_run != 0) last_pen_run = pen_run;
            pen_run = 0;
        end
        if (rst) begin
            m_armed   = 1'b1;
            m_ph      = P_IDLE;
            m_last_wr = 1'b0;
        end else begin
            case (m_ph)
                P_IDLE: if (gw || gr) begin
                    m_wr      = gw;
                    m_last_wr = gw;
                    m_addr    = gw ? rq.wr_addr_i : rq.rd_addr_i;
                    m_data    = rq.wr_data_i;
                    m_strb    = gw ? rq.wr_strb_i : 4'h0;
                    grants.push_back(gw);
                    hs_cyc    = cyc;
                    m_ph      = P_SETUP;
                end
                P_SETUP: begin
                    m_wait = 0;
                    m_ph   = P_ACCESS;
                end
                P_ACCESS: if (apb.pready_i) begin
                    m_rdata = m_wr ? 32'h0 : apb.prdata_i;
                    m_err   = apb.pslverr_i;
                    m_ph    = P_RESP;
                end else begin
                    m_wait++;
`ifdef APB_RW_SCHED_TIMEOUT_EN
                    if (m_wait == TMO) begin
                        m_rdata = 32'h0;
                        m_err   = 1'b1;
                        m_ph    = P_RESP;
                    end
`endif
                end
                default: begin
                    if (m_wr ? rq.wr_rsp_ready_i : rq.rd_rsp_ready_i)
                        m_ph = P_IDLE;
                end
            endcase
        end
    end

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input bit w, input logic [11:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        output int hs);
        int n0;
        @(posedge clk);
        #1;
        n0 = grants.size();
        if (w) begin
            rq.wr_req_valid_i = 1'b1;
            rq.wr_addr_i = a;
            rq.wr_data_i = d;
            rq.wr_strb_i = s;
        end else begin
            rq.rd_req_valid_i = 1'b1;
            rq.rd_addr_i = a;
        end
        hs = -1;
        for (int i = 0; i < 64; i++) begin
            at_neg();
            if (grants.size() > n0) begin
                hs = hs_cyc;
                break;
            end
        end
        @(posedge clk);
        #1;
        if (w) rq.wr_req_valid_i = 1'b0;
        else   rq.rd_req_valid_i = 1'b0;
        check(w ? "wr_handshake" : "rd_handshake", hs >= 0, 1);
    endtask

    task automatic wait_rsp(input bit w, output int c);
        c = -1;
        for (int i = 0; i < 64; i++) begin
            at_neg();
            if ((w ? rq.wr_rsp_valid_o : rq.rd_rsp_valid_o) === 1'b1) begin
                c = cyc;
                break;
            end
        end
        check(w ? "wr_rsp_arrives" : "rd_rsp_arrives", c >= 0, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    int hs, c, base;

    initial begin
        rst = 1'b1;
        rq.wr_req_valid_i = 1'b0;
        rq.rd_req_valid_i = 1'b0;
        rq.wr_addr_i = '0;
        rq.wr_data_i = '0;
        rq.wr_strb_i = '0;
        rq.rd_addr_i = '0;
        rq.wr_rsp_ready_i = 1'b1;
        rq.rd_rsp_ready_i = 1'b1;
        apb.pready_i  = 1'b0;
        apb.prdata_i  = '0;
        apb.pslverr_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        at_neg();
        check("rst_psel", apb.psel_o, 0);
        check("rst_penable", apb.penable_o, 0);
        check("rst_paddr", apb.paddr_o, 0);
        check("rst_pwrite", apb.pwrite_o, 0);
        check("rst_rsp_valid", {rq.wr_rsp_valid_o, rq.rd_rsp_valid_o}, 0);

        // single zero-wait write
        send(1'b1, 12'h010, 32'hDEADBEEF, 4'hF, hs);
        wait_rsp(1'b1, c);
        check("wr_latency", c - hs, 3);
        check("wr_err", rq.wr_rsp_err_o, 0);

        // read with three wait states
        slv_waits = 3;
        slv_rdata = 32'h12345678;
        send(1'b0, 12'h020, 32'h0, 4'h0, hs);
        wait_rsp(1'b0, c);
        check("rd_data", rq.rd_rsp_data_o, 32'h12345678);
        check("rd_err", rq.rd_rsp_err_o, 0);
        check("penable_cycles", last_pen_run, 4);
        check("rd_latency", c - hs, 6);

        // both channels valid: strict alternation
        slv_waits = 0;
        @(posedge clk);
        #1;
        base = grants.size();
        rq.wr_req_valid_i = 1'b1;
        rq.wr_addr_i = 12'h100;
        rq.wr_data_i = 32'hA5A5_0001;
        rq.wr_strb_i = 4'h3;
        rq.rd_req_valid_i = 1'b1;
        rq.rd_addr_i = 12'h200;
        for (int i = 0; i < 100; i++) begin
            at_neg();
            if (grants.size() >= base + 4) break;
        end
        @(posedge clk);
        #1;
        rq.wr_req_valid_i = 1'b0;
        rq.rd_req_valid_i = 1'b0;
        check("alt_count", grants.size() - base, 4);
        for (int k = 0; k < 4; k++)
            if (grants.size() > base + k)
                check("grant_order", grants[base+k], (k % 2) == 0);
        check("both_ready", both_rdy, 0);
        repeat (8) at_neg();

        // read error with stalled response consumer
        rq.rd_rsp_ready_i = 1'b0;
        slv_err = 1'b1;
        send(1'b0, 12'h030, 32'h0, 4'h0, hs);
        wait_rsp(1'b0, c);
        for (int i = 0; i < 5; i++) begin
            check("err_rsp_valid", rq.rd_rsp_valid_o, 1);
            check("err_rsp_err", rq.rd_rsp_err_o, 1);
            check("no_grant_in_resp", rq.wr_req_ready_o, 0);
            @(posedge clk);
            #1;
            rq.wr_req_valid_i = 1'b1;
            rq.wr_addr_i = 12'h044;
            rq.wr_data_i = 32'hCAFE_F00D;
            rq.wr_strb_i = 4'hC;
            slv_err = 1'b0;
            if (i == 4) rq.rd_rsp_ready_i = 1'b1;
            at_neg();
        end
        check("no_bypass", rq.wr_req_ready_o, 0);
        check("consume_valid", rq.rd_rsp_valid_o, 1);
        at_neg();
        check("after_consume", rq.rd_rsp_valid_o, 0);
        check("grant_after", rq.wr_req_ready_o, 1);
        @(posedge clk);
        #1;
        rq.wr_req_valid_i = 1'b0;
        wait_rsp(1'b1, c);
        check("wr_after_err", rq.wr_rsp_err_o, 0);

        // reset in the middle of ACCESS
        slv_waits = 6;
        send(1'b1, 12'h050, 32'h1111_2222, 4'hF, hs);
        for (int i = 0; i < 20; i++) begin
            if (apb.penable_o === 1'b1) break;
            at_neg();
        end
        check("reached_access", apb.penable_o, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        slv_waits = 0;
        at_neg();
        check("rst_mid_psel", apb.psel_o, 0);
        check("rst_mid_penable", apb.penable_o, 0);
        for (int i = 0; i < 3; i++) begin
            check("rst_no_rsp", rq.wr_rsp_valid_o, 0);
            at_neg();
        end
        send(1'b1, 12'h060, 32'h3333_4444, 4'h5, hs);
        wait_rsp(1'b1, c);
        check("post_rst_latency", c - hs, 3);
        check("post_rst_err", rq.wr_rsp_err_o, 0);

`ifdef APB_RW_SCHED_TIMEOUT_EN
        slv_waits = 1000;
        send(1'b0, 12'h070, 32'h0, 4'h0, hs);
        wait_rsp(1'b0, c);
        check("tmo_latency", c - hs, TMO + 2);
        check("tmo_err", rq.rd_rsp_err_o, 1);
        check("tmo_data", rq.rd_rsp_data_o, 0);
        slv_waits = 0;
        repeat (4) at_neg();
`endif

        // random traffic
        slv_rand = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            rq.wr_req_valid_i = $urandom % 2;
            rq.rd_req_valid_i = $urandom % 2;
            rq.wr_addr_i = 12'($urandom);
            rq.wr_data_i = $urandom;
            rq.wr_strb_i = 4'($urandom);
            rq.rd_addr_i = 12'($urandom);
            rq.wr_rsp_ready_i = ($urandom % 4) != 0;
            rq.rd_rsp_ready_i = ($urandom % 4) != 0;
        end
        @(posedge clk);
        #1;
        rq.wr_req_valid_i = 1'b0;
        rq.rd_req_valid_i = 1'b0;
        rq.wr_rsp_ready_i = 1'b1;
        rq.rd_rsp_ready_i = 1'b1;
        slv_rand = 1'b0;
        repeat (12) at_neg();
        check("rand_drained", {apb.psel_o, rq.wr_rsp_valid_o,
                               rq.rd_rsp_valid_o}, 0);
        check("rand_both_ready", both_rdy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule
